// File: rtl/flappy_game_ctrl.sv
// Flappy-bird game sequencer: button debounce, frame-divided bird stepping,
// IDLE/PLAY/DYING/OVER state machine and two-digit BCD score.
// Optional feature macro: HISCORE_EN adds a BCD high-score output o_hiscore.
module flappy_game_ctrl #(
  parameter int DEB_CYCLES   = 250000,
  parameter int FRAME_DIV    = 1,
  parameter int DEATH_FRAMES = 60
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_btn,
  input  logic       i_frame,
  input  logic       i_oob,
  input  logic       i_hit,
  input  logic       i_pipe_passed,
  output logic       o_bird_rst,
  output logic       o_bird_step,
  output logic       o_flap,
  output logic [1:0] o_state,
  output logic [7:0] o_score
`ifdef HISCORE_EN
  ,
  output logic [7:0] o_hiscore
`endif
);

  localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST   = DEB_W'(DEB_CYCLES - 1);
  localparam logic [3:0]       DIV_LAST   = 4'(FRAME_DIV - 1);
  localparam logic [7:0]       DEATH_LAST = 8'(DEATH_FRAMES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLAY  = 2'd1,
    S_DYING = 2'd2,
    S_OVER  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_btn_s1;
  logic             r_btn_s2;
  logic             r_btn_deb;
  logic             r_btn_deb_d;
  logic [DEB_W-1:0] r_deb_cnt;
  logic             r_press;
  logic [3:0]       r_div;
  logic [7:0]       r_death;
  logic             r_crash;
  logic             r_pend;
  logic             r_step;
  logic [7:0]       r_score;
  logic             w_frame_hit;
  logic             w_start_go;
  logic             w_crash_go;
  logic             w_over_go;
  logic             w_step_nxt;

  function automatic logic [7:0] bcd_inc(input logic [7:0] s);
    logic [7:0] r;
    r = s;
    if (s != 8'h99) begin
      if (s[3:0] == 4'd9) r = {s[7:4] + 4'd1, 4'd0};
      else                r = {s[7:4], s[3:0] + 4'd1};
    end
    return r;
  endfunction

  // Crash is judged on the registered sticky flag, so a flag raised on the
  // i_frame cycle itself takes effect at the following frame.
  always_comb begin
    w_frame_hit = i_frame && (r_div == DIV_LAST);
    w_start_go  = (r_state == S_IDLE)  && i_frame && r_pend;
    w_crash_go  = (r_state == S_PLAY)  && i_frame && r_crash;
    w_over_go   = (r_state == S_DYING) && i_frame && (r_death == DEATH_LAST);
    w_step_nxt  = w_frame_hit &&
                  (((r_state == S_PLAY) && !r_crash) ||
                   ((r_state == S_DYING) && !w_over_go));
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start_go) w_state_nxt = S_PLAY;
      S_PLAY:  if (w_crash_go) w_state_nxt = S_DYING;
      S_DYING: if (w_over_go)  w_state_nxt = S_OVER;
      S_OVER:  if (r_press)    w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Synchronizer, stability counter and one-cycle press pulse on debounced rise.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_btn_s1    <= 1'b0;
      r_btn_s2    <= 1'b0;
      r_btn_deb   <= 1'b0;
      r_btn_deb_d <= 1'b0;
      r_deb_cnt   <= '0;
      r_press     <= 1'b0;
    end else begin
      r_btn_s1 <= i_btn;
      r_btn_s2 <= r_btn_s1;
      if (r_btn_s2 != r_btn_deb) begin
        if (r_deb_cnt == DEB_LAST) begin
          r_btn_deb <= r_btn_s2;
          r_deb_cnt <= '0;
        end else begin
          r_deb_cnt <= r_deb_cnt + 1'b1;
        end
      end else begin
        r_deb_cnt <= '0;
      end
      r_btn_deb_d <= r_btn_deb;
      r_press     <= r_btn_deb & ~r_btn_deb_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_div   <= '0;
      r_death <= '0;
      r_crash <= 1'b0;
      r_pend  <= 1'b0;
      r_step  <= 1'b0;
      r_score <= 8'h00;
    end else begin
      r_step <= w_step_nxt;

      if (w_start_go || w_crash_go)
        r_div <= '0;
      else if (((r_state == S_PLAY) || (r_state == S_DYING)) && i_frame)
        r_div <= w_frame_hit ? 4'd0 : r_div + 4'd1;

      if (w_crash_go)
        r_death <= '0;
      else if ((r_state == S_DYING) && i_frame)
        r_death <= w_over_go ? 8'd0 : r_death + 8'd1;

      if ((r_state == S_PLAY) && !w_crash_go) r_crash <= r_crash | i_oob | i_hit;
      else                                    r_crash <= 1'b0;

      // A press landing on a step cycle survives for the next step.
      case (r_state)
        S_IDLE: if (r_press) r_pend <= 1'b1;
        S_PLAY: begin
          if (w_crash_go)   r_pend <= 1'b0;
          else if (r_step)  r_pend <= r_press;
          else if (r_press) r_pend <= 1'b1;
        end
        default: r_pend <= 1'b0;
      endcase

      if ((r_state == S_IDLE) && r_press)
        r_score <= 8'h00;
      else if ((r_state == S_PLAY) && i_pipe_passed && !w_crash_go)
        r_score <= bcd_inc(r_score);
    end
  end

`ifdef HISCORE_EN
  logic [7:0] r_hiscore;

  // BCD digits order the same way as binary, so a plain compare works.
  always_ff @(posedge i_clk) begin
    if (i_rst)                                  r_hiscore <= 8'h00;
    else if (w_crash_go && (r_score > r_hiscore)) r_hiscore <= r_score;
  end

  assign o_hiscore = r_hiscore;
`endif

  assign o_state     = r_state;
  assign o_bird_rst  = (r_state == S_IDLE);
  assign o_bird_step = r_step;
  assign o_flap      = r_step & r_pend & (r_state == S_PLAY);
  assign o_score     = r_score;

endmodule

// File: tb/tb_flappy_game_ctrl.sv
// Directed bench for flappy_game_ctrl: a vector table for start-up and frame
// division, then hand-written sequences for presses, crash, score and reset.
module tb_flappy_game_ctrl;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_btn = 1'b0;
  logic       i_frame = 1'b0;
  logic       i_oob = 1'b0;
  logic       i_hit = 1'b0;
  logic       i_pipe_passed = 1'b0;
  logic       o_bird_rst;
  logic       o_bird_step;
  logic       o_flap;
  logic [1:0] o_state;
  logic [7:0] o_score;
`ifdef HISCORE_EN
  logic [7:0] o_hiscore;
`endif

  int n_chk = 0;
  int n_err = 0;
  int n_step = 0;
  int n_flap = 0;

  flappy_game_ctrl #(
    .DEB_CYCLES(4),
    .FRAME_DIV(2),
    .DEATH_FRAMES(3)
  ) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_btn(i_btn),
    .i_frame(i_frame),
    .i_oob(i_oob),
    .i_hit(i_hit),
    .i_pipe_passed(i_pipe_passed),
    .o_bird_rst(o_bird_rst),
    .o_bird_step(o_bird_step),
    .o_flap(o_flap),
    .o_state(o_state),
    .o_score(o_score)
`ifdef HISCORE_EN
    ,
    .o_hiscore(o_hiscore)
`endif
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic       btn;
    logic       frame;
    logic       pipe;
    logic [1:0] st;
    logic       step;
    logic       flap;
    logic       brst;
    logic [7:0] score;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic btn, frame, pipe, input logic [1:0] st,
                              input logic step, flap, brst, input logic [7:0] score);
    vec_t v;
    v.btn = btn; v.frame = frame; v.pipe = pipe; v.st = st;
    v.step = step; v.flap = flap; v.brst = brst; v.score = score;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
    if (o_bird_step) n_step++;
    if (o_flap) begin
      n_flap++;
      chk("flap_with_step", {7'd0, o_bird_step}, 8'd1);
    end
  endtask

  task automatic cyc(input logic btn, frame, oob, hit, pipe);
    i_btn = btn; i_frame = frame; i_oob = oob; i_hit = hit; i_pipe_passed = pipe;
    tick();
  endtask

  task automatic do_press();
    for (int i = 0; i < 7; i++) cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) cyc(0, 0, 0, 0, 0);
  endtask

  task automatic start_game();
    do_press();
    cyc(0, 1, 0, 0, 0);
    chk("start_state", {6'd0, o_state}, 8'd1);
    chk("start_score", o_score, 8'h00);
    chk("start_bird_rst", {7'd0, o_bird_rst}, 8'd0);
  endtask

  task automatic pipes(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0);
    end
  endtask

  task automatic crash(input logic use_hit, input logic pipe_too);
    cyc(0, 0, !use_hit, use_hit, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, pipe_too);
    chk("crash_state", {6'd0, o_state}, 8'd2);
    chk("crash_no_step", {7'd0, o_bird_step}, 8'd0);
    cyc(0, 0, 0, 0, 0);
    chk("crash_no_step_after", {7'd0, o_bird_step}, 8'd0);
  endtask

  task automatic finish_dying();
    int s0;
    s0 = n_step;
    cyc(0, 1, 0, 0, 0);
    chk("dying_f1_state", {6'd0, o_state}, 8'd2);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    chk("dying_f2_state", {6'd0, o_state}, 8'd2);
    chk("dying_f2_step", {7'd0, o_bird_step}, 8'd1);
    chk("dying_f2_flap", {7'd0, o_flap}, 8'd0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    chk("dying_f3_state", {6'd0, o_state}, 8'd3);
    chk("over_bird_rst", {7'd0, o_bird_rst}, 8'd0);
    cyc(0, 0, 0, 0, 0);
    chk("dying_step_count", 8'(n_step - s0), 8'd1);
  endtask

  task automatic return_idle();
    for (int i = 0; i < 7; i++) cyc(1, 0, 0, 0, 0);
    chk("over_hold_state", {6'd0, o_state}, 8'd3);
    cyc(0, 0, 0, 0, 0);
    chk("over_to_idle_state", {6'd0, o_state}, 8'd0);
    chk("idle_bird_rst", {7'd0, o_bird_rst}, 8'd1);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0;

    // Start-up with held button, then frame division by 2 with two pipe pulses.
    for (int i = 0; i < 10; i++) add(1, 0, 0, 2'd0, 0, 0, 1, 8'h00);
    add(0, 1, 0, 2'd1, 0, 0, 0, 8'h00);
    add(0, 0, 0, 2'd1, 0, 0, 0, 8'h00);
    add(0, 1, 0, 2'd1, 0, 0, 0, 8'h00);
    add(0, 0, 0, 2'd1, 0, 0, 0, 8'h00);
    add(0, 1, 0, 2'd1, 1, 1, 0, 8'h00);
    add(0, 0, 0, 2'd1, 0, 0, 0, 8'h00);
    for (int k = 1; k <= 6; k++) begin
      add(0, 1, 0, 2'd1, (k % 2 == 0), 0, 0, (k <= 1) ? 8'h00 : (k <= 3) ? 8'h01 : 8'h02);
      add(0, 0, (k == 1 || k == 3), 2'd1, 0, 0, 0, (k < 3) ? 8'h01 : 8'h02);
      add(0, 0, 0, 2'd1, 0, 0, 0, (k < 3) ? 8'h01 : 8'h02);
    end

    tick();
    tick();
    chk("rst_state", {6'd0, o_state}, 8'd0);
    chk("rst_bird_rst", {7'd0, o_bird_rst}, 8'd1);
    chk("rst_step", {7'd0, o_bird_step}, 8'd0);
    chk("rst_flap", {7'd0, o_flap}, 8'd0);
    chk("rst_score", o_score, 8'h00);
`ifdef HISCORE_EN
    chk("rst_hiscore", o_hiscore, 8'h00);
`endif
    i_rst = 1'b0;

    foreach (vecs[i]) begin
      cyc(vecs[i].btn, vecs[i].frame, 0, 0, vecs[i].pipe);
      chk($sformatf("vec%0d_state", i), {6'd0, o_state}, {6'd0, vecs[i].st});
      chk($sformatf("vec%0d_step", i), {7'd0, o_bird_step}, {7'd0, vecs[i].step});
      chk($sformatf("vec%0d_flap", i), {7'd0, o_flap}, {7'd0, vecs[i].flap});
      chk($sformatf("vec%0d_brst", i), {7'd0, o_bird_rst}, {7'd0, vecs[i].brst});
      chk($sformatf("vec%0d_score", i), o_score, vecs[i].score);
    end

    // Three presses between steps collapse into a single flap.
    f0 = n_flap;
    do_press();
    do_press();
    do_press();
    cyc(0, 1, 0, 0, 0);
    chk("multi_press_no_step", {7'd0, o_bird_step}, 8'd0);
    cyc(0, 1, 0, 0, 0);
    chk("multi_press_step", {7'd0, o_bird_step}, 8'd1);
    chk("multi_press_flap", {7'd0, o_flap}, 8'd1);
    cyc(0, 0, 0, 0, 0);
    chk("multi_press_flap_count", 8'(n_flap - f0), 8'd1);

    // Press pulse coinciding with a step cycle carries over to the next step.
    cyc(0, 1, 0, 0, 0);
    for (int i = 1; i <= 7; i++) cyc(1, (i == 7), 0, 0, 0);
    chk("step_press_step", {7'd0, o_bird_step}, 8'd1);
    chk("step_press_flap_now", {7'd0, o_flap}, 8'd0);
    for (int i = 0; i < 7; i++) cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    chk("step_press_step_next", {7'd0, o_bird_step}, 8'd1);
    chk("step_press_flap_next", {7'd0, o_flap}, 8'd1);
    cyc(0, 0, 0, 0, 0);

    // Out-of-bounds mid-frame with the divider one short of a step.
    cyc(0, 1, 0, 0, 0);
    crash(0, 0);
    finish_dying();
    chk("over_score_held", o_score, 8'h02);
    return_idle();
    chk("idle_score_held", o_score, 8'h02);

    // Game A: score 12, pipe pulse on the crash frame is not counted.
    start_game();
    pipes(10);
    chk("score_10", o_score, 8'h10);
    pipes(2);
    chk("score_12", o_score, 8'h12);
    crash(0, 1);
    chk("crash_pipe_ignored", o_score, 8'h12);
`ifdef HISCORE_EN
    chk("hiscore_12", o_hiscore, 8'h12);
`endif
    finish_dying();
    return_idle();
    chk("idle_score_12", o_score, 8'h12);

    // Game B: lower score leaves the high score alone.
    start_game();
`ifdef HISCORE_EN
    chk("hiscore_survives_clear", o_hiscore, 8'h12);
`endif
    pipes(5);
    chk("score_05", o_score, 8'h05);
    crash(1, 0);
`ifdef HISCORE_EN
    chk("hiscore_kept_12", o_hiscore, 8'h12);
`endif
    finish_dying();
    return_idle();

    // Game C: saturation, then reset in the middle of DYING.
    start_game();
    pipes(99);
    chk("score_99", o_score, 8'h99);
    pipes(1);
    chk("score_sat_99", o_score, 8'h99);
    crash(0, 0);
`ifdef HISCORE_EN
    chk("hiscore_99", o_hiscore, 8'h99);
`endif
    cyc(0, 1, 0, 0, 0);
    chk("pre_rst_dying", {6'd0, o_state}, 8'd2);
    i_rst = 1'b1;
    cyc(0, 1, 0, 0, 0);
    chk("mid_rst_state", {6'd0, o_state}, 8'd0);
    chk("mid_rst_bird_rst", {7'd0, o_bird_rst}, 8'd1);
    chk("mid_rst_step", {7'd0, o_bird_step}, 8'd0);
    chk("mid_rst_flap", {7'd0, o_flap}, 8'd0);
    chk("mid_rst_score", o_score, 8'h00);
`ifdef HISCORE_EN
    chk("mid_rst_hiscore", o_hiscore, 8'h00);
`endif
    i_rst = 1'b0;
    cyc(0, 0, 0, 0, 0);
    chk("post_rst_state", {6'd0, o_state}, 8'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
